i_cache_ctrl_nway: RTL and testbench

//  Parametrised N-way set-associative I-cache controller with multi-beat line refill.

---
 rtl/i_cache_ctrl_nway.sv | 206 ++++++++++++++++++++
 tb/tb_i_cache_ctrl_nway.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i_cache_ctrl_nway.sv
// N-way set-associative I-cache controller: valid/LRU ownership, miss refill FSM, CACHE ops.
// Optional ICACHE_PERF_EN adds saturating fetch hit/miss counters.
module i_cache_ctrl_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    localparam int IDX_W     = $clog2(SETS),
    localparam int WAY_W     = $clog2(WAYS),
    localparam int WD_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req_valid,
    input  logic [2:0]       i_req_op,
    input  logic [IDX_W-1:0] i_req_index,
    input  logic [WAY_W-1:0] i_req_way,
    input  logic [WAYS-1:0]  i_tag_match,
    input  logic             i_cache_err,
    output logic             o_mem_req,
    input  logic             i_mem_gnt,
    input  logic             i_mem_rvalid,
    output logic             o_hit,
    output logic [WAY_W-1:0] o_hit_way,
    output logic             o_cache_ready,
    output logic [WAYS-1:0]  o_tag_we,
    output logic [WAYS-1:0]  o_data_we,
    output logic [WD_W-1:0]  o_fill_word,
    output logic [31:0]      o_hit_cnt,
    output logic [31:0]      o_miss_cnt
);

    // state  | meaning
    // S_IDLE | serve fetch hits and CACHE ops in one cycle
    // S_REQ  | line read requested, waiting for grant
    // S_FILL | collecting LINE_WORDS refill beats into the victim way
    // S_DONE | write victim tag, mark valid, make victim MRU
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_DONE} state_t;

    localparam logic [2:0] OP_FETCH = 3'd0;
    localparam logic [2:0] OP_IINV  = 3'd1;
    localparam logic [2:0] OP_AINV  = 3'd2;
    localparam logic [2:0] OP_TAGST = 3'd3;

    state_t           r_state, w_state_nxt;
    logic [WAYS-1:0]  r_valid [SETS];
    logic [WAY_W-1:0] r_age   [SETS][WAYS];
    logic [IDX_W-1:0] r_idx;
    logic [WAY_W-1:0] r_victim;
    logic [WD_W-1:0]  r_beat;

    logic [WAYS-1:0]  w_hit_vec;
    logic             w_hit_any;
    logic [WAY_W-1:0] w_hit_way;
    logic [WAY_W-1:0] w_victim;
    logic [IDX_W-1:0] w_upd_idx;
    logic             w_touch_en;
    logic [WAY_W-1:0] w_touch_way;
    logic             w_clr_en;
    logic [WAY_W-1:0] w_clr_way;
    logic             w_set_en;
    logic             w_miss_start;
    logic             w_beat_en;

    // Lowest hitting way; victim prefers lowest invalid way over the oldest way.
    always_comb begin
        w_hit_vec = i_tag_match & r_valid[i_req_index];
        w_hit_any = |w_hit_vec;
        w_hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
        w_victim = '0;
        for (int w = 0; w < WAYS; w++)
            if (r_age[i_req_index][w] == WAY_W'(WAYS - 1)) w_victim = WAY_W'(w);
        for (int w = WAYS - 1; w >= 0; w--)
            if (!r_valid[i_req_index][w]) w_victim = WAY_W'(w);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        o_mem_req     = 1'b0;
        o_hit         = 1'b0;
        o_hit_way     = '0;
        o_cache_ready = 1'b0;
        o_tag_we      = '0;
        o_data_we     = '0;
        o_fill_word   = '0;
        w_upd_idx     = i_req_index;
        w_touch_en    = 1'b0;
        w_touch_way   = w_hit_way;
        w_clr_en      = 1'b0;
        w_clr_way     = i_req_way;
        w_set_en      = 1'b0;
        w_miss_start  = 1'b0;
        w_beat_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_cache_ready = 1'b1;
                if (i_req_valid && (i_req_op == OP_FETCH || i_req_op == OP_AINV)) begin
                    o_hit     = w_hit_any;
                    o_hit_way = w_hit_way;
                end
                if (i_req_valid && !i_cache_err) begin
                    case (i_req_op)
                        OP_FETCH: begin
                            if (w_hit_any) begin
                                w_touch_en = 1'b1;
                            end else begin
                                o_cache_ready = 1'b0;
                                w_miss_start  = 1'b1;
                                w_state_nxt   = S_REQ;
                            end
                        end
                        OP_IINV:  w_clr_en = 1'b1;
                        OP_AINV: begin
                            w_clr_en  = w_hit_any;
                            w_clr_way = w_hit_way;
                        end
                        OP_TAGST: o_tag_we = WAYS'(1) << i_req_way;
                        default: ;
                    endcase
                end
            end
            S_REQ: begin
                o_mem_req = 1'b1;
                if (i_mem_gnt) w_state_nxt = S_FILL;
            end
            S_FILL: begin
                o_fill_word = r_beat;
                // Memory has committed the beat, so it is written even under cache_err.
                if (i_mem_rvalid) begin
                    o_data_we = WAYS'(1) << r_victim;
                    w_beat_en = 1'b1;
                    if (r_beat == WD_W'(LINE_WORDS - 1)) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_upd_idx = r_idx;
                if (!i_cache_err) begin
                    o_tag_we    = WAYS'(1) << r_victim;
                    w_set_en    = 1'b1;
                    w_touch_en  = 1'b1;
                    w_touch_way = r_victim;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                for (int w = 0; w < WAYS; w++) r_age[s][w] <= WAY_W'(w);
            end
            r_idx    <= '0;
            r_victim <= '0;
            r_beat   <= '0;
        end else begin
            if (w_miss_start) begin
                r_idx    <= i_req_index;
                r_victim <= w_victim;
                r_beat   <= '0;
            end
            if (w_beat_en) r_beat <= r_beat + 1'b1;
            if (w_clr_en)  r_valid[w_upd_idx][w_clr_way] <= 1'b0;
            if (w_set_en)  r_valid[w_upd_idx][r_victim]  <= 1'b1;
            // Younger-than-touched ways age by one; the ages remain a permutation.
            if (w_touch_en) begin
                for (int w = 0; w < WAYS; w++)
                    if (r_age[w_upd_idx][w] < r_age[w_upd_idx][w_touch_way])
                        r_age[w_upd_idx][w] <= r_age[w_upd_idx][w] + 1'b1;
                r_age[w_upd_idx][w_touch_way] <= '0;
            end
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;
    logic        w_cnt_hit;

    assign w_cnt_hit = w_touch_en && (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_cnt_hit && r_hit_cnt != 32'hFFFF_FFFF)     r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_miss_start && r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign o_hit_cnt  = r_hit_cnt;
    assign o_miss_cnt = r_miss_cnt;
`else
    assign o_hit_cnt  = '0;
    assign o_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_i_cache_ctrl_nway.sv
// Self-checking bench for i_cache_ctrl_nway (WAYS=2, SETS=64, LINE_WORDS=4).
// Table-driven single-cycle ops plus refill sequences checked through a beat scoreboard.
module tb_i_cache_ctrl_nway;
    localparam int LW = 4;

    logic        clk, rst;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [5:0]  req_index;
    logic        req_way;
    logic [1:0]  tag_match;
    logic        cache_err;
    logic        mem_req, mem_gnt, mem_rvalid;
    logic        hit, hit_way, cache_ready;
    logic [1:0]  tag_we, data_we, fill_word;
    logic [31:0] hit_cnt, miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    typedef struct {
        logic [1:0] fw;
        logic [1:0] we;
    } beat_t;
    beat_t sb[$];

    typedef struct {
        logic       v;
        logic [2:0] op;
        logic [5:0] idx;
        logic       way;
        logic [1:0] tm;
        logic       err;
        logic       e_hit;
        logic       e_way;
        logic       e_rdy;
        logic [1:0] e_twe;
        logic       e_mreq;
    } vec_t;
    vec_t vt[15];

    i_cache_ctrl_nway #(.WAYS(2), .SETS(64), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .i_req_op(req_op), .i_req_index(req_index),
        .i_req_way(req_way), .i_tag_match(tag_match), .i_cache_err(cache_err),
        .o_mem_req(mem_req), .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid),
        .o_hit(hit), .o_hit_way(hit_way), .o_cache_ready(cache_ready),
        .o_tag_we(tag_we), .o_data_we(data_we), .o_fill_word(fill_word),
        .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_op(input string nm, input logic v, input logic [2:0] op,
                           input logic [5:0] idx, input logic way, input logic [1:0] tm,
                           input logic err, input logic e_hit, input logic e_way,
                           input logic e_rdy, input logic [1:0] e_twe, input logic e_mreq);
        req_valid = v; req_op = op; req_index = idx; req_way = way;
        tag_match = tm; cache_err = err;
        @(negedge clk);
        check({nm, "_hit"}, hit, e_hit);
        check({nm, "_hit_way"}, hit_way, e_way);
        check({nm, "_ready"}, cache_ready, e_rdy);
        check({nm, "_tag_we"}, tag_we, e_twe);
        check({nm, "_mem_req"}, mem_req, e_mreq);
        check({nm, "_data_we"}, data_we, 2'b00);
        @(posedge clk); #1;
        req_valid = 1'b0; tag_match = 2'b00; cache_err = 1'b0;
        if (v && op == 3'd0 && !err && e_hit) exp_hits++;
    endtask

    // FETCH miss on idx, grant after gnt_dly cycles, beats gated by gaps (1 = no beat), then refetch hit.
    task automatic refill(input string nm, input logic [5:0] idx, input logic vic,
                          input int gnt_dly, input logic [7:0] gaps);
        beat_t b;
        int beats;
        int cyc;
        logic [1:0] we_exp;
        we_exp = 2'b01 << vic;
        req_valid = 1'b1; req_op = 3'd0; req_index = idx; tag_match = 2'b00;
        cache_err = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        check({nm, "_miss_ready"}, cache_ready, 1'b0);
        check({nm, "_miss_hit"}, hit, 1'b0);
        @(posedge clk); #1;
        for (int d = 0; d <= gnt_dly; d++) begin
            mem_gnt = (d == gnt_dly);
            @(negedge clk);
            check({nm, "_req_mem_req"}, mem_req, 1'b1);
            check({nm, "_req_ready"}, cache_ready, 1'b0);
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0;
        beats = 0;
        cyc = 0;
        while (beats < LW && cyc < 40) begin
            mem_rvalid = !gaps[cyc % 8];
            if (mem_rvalid) begin
                b.fw = 2'(beats);
                b.we = we_exp;
                sb.push_back(b);
                beats++;
            end
            @(negedge clk);
            if (data_we != 2'b00) begin
                if (sb.size() == 0) begin
                    check({nm, "_extra_write"}, data_we, 2'b00);
                end else begin
                    b = sb.pop_front();
                    check({nm, "_fill_word"}, fill_word, b.fw);
                    check({nm, "_data_we"}, data_we, b.we);
                end
            end
            check({nm, "_fill_mem_req"}, mem_req, 1'b0);
            check({nm, "_fill_ready"}, cache_ready, 1'b0);
            @(posedge clk); #1;
            cyc++;
        end
        if (beats < LW) check({nm, "_beat_timeout"}, beats, LW);
        mem_rvalid = 1'b1;
        @(negedge clk);
        check({nm, "_done_tag_we"}, tag_we, we_exp);
        check({nm, "_done_data_we"}, data_we, 2'b00);
        check({nm, "_done_ready"}, cache_ready, 1'b0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check({nm, "_sb_empty"}, sb.size(), 0);
        sb.delete();
        tag_match = we_exp;
        @(negedge clk);
        check({nm, "_refetch_hit"}, hit, 1'b1);
        check({nm, "_refetch_way"}, hit_way, vic);
        check({nm, "_refetch_ready"}, cache_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0; tag_match = 2'b00;
        exp_misses++;
        exp_hits++;
    endtask

    initial begin
        // v, op, idx, way, tm, err | hit, hit_way, ready, tag_we, mem_req
        vt[0]  = '{1'b0, 3'd0, 6'd5, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        vt[1]  = '{1'b1, 3'd0, 6'd5, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0};
        vt[2]  = '{1'b1, 3'd2, 6'd5, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        vt[3]  = '{1'b1, 3'd3, 6'd7, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0};
        vt[4]  = '{1'b1, 3'd5, 6'd3, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        vt[5]  = '{1'b1, 3'd2, 6'd3, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0};
        vt[6]  = '{1'b1, 3'd0, 6'd3, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0};
        vt[7]  = '{1'b1, 3'd0, 6'd3, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0};
        vt[8]  = '{1'b1, 3'd1, 6'd5, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        vt[9]  = '{1'b1, 3'd0, 6'd5, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0};
        vt[10] = '{1'b1, 3'd2, 6'd5, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0};
        vt[11] = '{1'b1, 3'd2, 6'd5, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        vt[12] = '{1'b1, 3'd3, 6'd5, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        vt[13] = '{1'b1, 3'd0, 6'd9, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        vt[14] = '{1'b1, 3'd0, 6'd9, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};

        rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_index = '0; req_way = 1'b0;
        tag_match = 2'b00; cache_err = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", cache_ready, 1'b1);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_hit", hit, 1'b0);
        check("rst_hit_way", hit_way, 1'b0);
        check("rst_tag_we", tag_we, 2'b00);
        check("rst_data_we", data_we, 2'b00);
        check("rst_fill_word", fill_word, 2'b00);
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
        @(posedge clk); #1;

        refill("t1", 6'd5, 1'b0, 0, 8'h00);
        refill("t2a", 6'd3, 1'b0, 0, 8'h00);
        refill("t2b", 6'd3, 1'b1, 0, 8'h00);
        idle_op("t2_hit0", 1'b1, 3'd0, 6'd3, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
        refill("t2_lru", 6'd3, 1'b1, 1, 8'h02);
        idle_op("t3_inv", 1'b1, 3'd1, 6'd3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        refill("t3_invfirst", 6'd3, 1'b1, 3, 8'h2D);

        for (int i = 0; i < 15; i++)
            idle_op($sformatf("vec%0d", i), vt[i].v, vt[i].op, vt[i].idx, vt[i].way, vt[i].tm,
                    vt[i].err, vt[i].e_hit, vt[i].e_way, vt[i].e_rdy, vt[i].e_twe, vt[i].e_mreq);

        // A cache_err hit on way 0 must not have refreshed it, so way 0 is still the oldest.
        refill("t5_err_lru", 6'd3, 1'b0, 0, 8'h00);
`ifdef ICACHE_PERF_EN
        check("cnt_hits", hit_cnt, exp_hits);
        check("cnt_misses", miss_cnt, exp_misses);
`else
        check("cnt_hits_off", hit_cnt, 32'd0);
        check("cnt_misses_off", miss_cnt, 32'd0);
`endif

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        refill("t6", 6'd2, 1'b0, 0, 8'h00);
        idle_op("t6_hit2", 1'b1, 3'd0, 6'd2, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
        idle_op("t6_hit3", 1'b1, 3'd0, 6'd2, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
        @(negedge clk);
`ifdef ICACHE_PERF_EN
        check("t6_hit_cnt", hit_cnt, 32'd3);
        check("t6_miss_cnt", miss_cnt, 32'd1);
`else
        check("t6_hit_cnt_off", hit_cnt, 32'd0);
        check("t6_miss_cnt_off", miss_cnt, 32'd0);
`endif
        @(posedge clk); #1;

        req_valid = 1'b1; req_op = 3'd0; req_index = 6'd4; tag_match = 2'b00;
        @(negedge clk);
        check("t7_miss_ready", cache_ready, 1'b0);
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(negedge clk);
        check("t7_mem_req", mem_req, 1'b1);
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b1;
        @(negedge clk);
        check("t7_beat0_we", data_we, 2'b01);
        check("t7_beat0_word", fill_word, 2'b00);
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t7_abort_mem_req", mem_req, 1'b0);
        check("t7_abort_ready", cache_ready, 1'b1);
        check("t7_late_beat_we", data_we, 2'b00);
        check("t7_hit_cnt", hit_cnt, 32'd0);
        check("t7_miss_cnt", miss_cnt, 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        idle_op("t7_idx4_invalid", 1'b1, 3'd2, 6'd4, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        idle_op("t7_idx2_invalid", 1'b1, 3'd2, 6'd2, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
